alu_issue_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit ALU (opcode-decoded, 16 functional units).
- Accepts operation requests over valid/ready from two clients and grants them round-robin.
- Drives the ALU's opcode/operand/enable inputs for the operation's fixed latency, captures the result and returns it with requester ID over a valid/ready response channel.
- Sits between the instruction issue logic and the alu datapath; at most one operation is in flight.

---
 rtl/alu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin arbiter that sequences one op at a time through the shared ALU.
module alu_issue_ctrl #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3,
   parameter int FP_LAT  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             alu_enable,
   output logic [4:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_err,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic             rr_q, rr_d, id_q, id_d, err_q, err_d;
   logic [3:0]       cnt_q, cnt_d, lat;
   logic [4:0]       op_q, op_d, gnt_op;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic             gnt_any, gnt_id;
   assign gnt_any = req0_valid | req1_valid;
   assign gnt_id  = (req0_valid & req1_valid) ? rr_q : req1_valid;
   assign gnt_op  = gnt_id ? req1_opcode : req0_opcode;
   assign lat     = (gnt_op == 5'd4) ? 4'(MUL_LAT) :
                    (gnt_op inside {[5'd5:5'd7]}) ? 4'(FP_LAT) : 4'd1;
   assign req0_ready = (state_q == IDLE) & req0_valid & ~gnt_id;
   assign req1_ready = (state_q == IDLE) & req1_valid & gnt_id;
   assign alu_enable = state_q == EXEC;
   assign resp_valid = state_q == RESP;
   assign busy       = state_q != IDLE;
   assign alu_opcode = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign resp_id    = id_q;
   assign resp_data  = data_q;
   assign resp_err   = err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
      end
   end
   // ALU-facing registers only load on a legal accept so they hold through illegal ops.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (gnt_any) begin
            id_d = gnt_id;
            rr_d = ~gnt_id;
            if (gnt_op[4]) begin
               err_d   = 1'b1;
               data_d  = '0;
               state_d = RESP;
            end else begin
               op_d    = gnt_op;
               a_d     = gnt_id ? req1_a : req0_a;
               b_d     = gnt_id ? req1_b : req0_b;
               cnt_d   = lat - 4'd1;
               state_d = EXEC;
            end
         end
         EXEC: if (cnt_q == 4'd0) begin
            data_d  = alu_result;
            err_d   = 1'b0;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized transaction-level check of alu_issue_ctrl against a behavioural model.
module tb_alu_issue_ctrl;
   localparam int MUL_LAT = 3;
   localparam int FP_LAT  = 4;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
   logic [4:0]  req0_opcode = 0, req1_opcode = 0, alu_opcode;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic        alu_enable, resp_valid, resp_ready = 0, resp_id, resp_err, busy;
   logic [31:0] alu_a, alu_b, alu_result, resp_data;
   int          checks = 0, errors = 0, en_cnt;
   logic        v[2];
   logic [4:0]  opm[2];
   logic [31:0] am[2], bm[2];
   logic        prio;
   logic [4:0]  last_op;
   logic [31:0] last_a, last_b;

   alu_issue_ctrl #(.WIDTH(32), .MUL_LAT(MUL_LAT), .FP_LAT(FP_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err), .busy(busy));

   always #5 clk = ~clk;

   function automatic int lat_of(input logic [4:0] op);
      if (op >= 5'd16) return 0;
      if (op == 5'd4) return MUL_LAT;
      if (op >= 5'd5 && op <= 5'd7) return FP_LAT;
      return 1;
   endfunction

   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'd0: return a + b;
         5'd1: return a + b + 1;
         5'd2: return a - b;
         5'd3: return a - b - 1;
         5'd4: return a * b;
         5'd8: return a & b;
         5'd9: return a | b;
         5'd10: return a ^ b;
         default: return (a ^ b) + 32'(op);
      endcase
   endfunction

   // ALU model: correct result only in the op's final enabled cycle, garbage otherwise.
   always @(posedge clk or posedge rst)
      if (rst) en_cnt <= 1;
      else en_cnt <= alu_enable ? en_cnt + 1 : 1;
   assign alu_result = (alu_enable && en_cnt == lat_of(alu_opcode)) ?
                       alu_f(alu_opcode, alu_a, alu_b) : ~alu_f(alu_opcode, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive();
      req0_valid = v[0]; req0_opcode = opm[0]; req0_a = am[0]; req0_b = bm[0];
      req1_valid = v[1]; req1_opcode = opm[1]; req1_a = am[1]; req1_b = bm[1];
   endtask

   task automatic model_reset();
      v[0] = 0; v[1] = 0; prio = 0; last_op = 0; last_a = 0; last_b = 0;
      opm[0] = 0; opm[1] = 0; am[0] = 0; am[1] = 0; bm[0] = 0; bm[1] = 0;
   endtask

   task automatic load(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      v[id] = 1; opm[id] = op; am[id] = a; bm[id] = b;
   endtask

   function automatic logic [4:0] rnd_op();
      return ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
   endfunction

   // Called at posedge+1 in IDLE: grant, execute, respond after `hold` stalled cycles.
   task automatic serve(input int hold);
      int g, k, ne, lat;
      logic ill;
      logic [4:0] op;
      logic [31:0] a, b, exp;
      drive();
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_resp_valid", resp_valid, 0);
      g = (v[0] && v[1]) ? int'(prio) : (v[1] ? 1 : 0);
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      op = opm[g]; a = am[g]; b = bm[g];
      ill = op >= 5'd16;
      lat = lat_of(op);
      exp = ill ? 32'd0 : alu_f(op, a, b);
      @(posedge clk);
      #1;
      v[g] = 0;
      drive();
      prio = (g == 0);
      if (!ill) begin last_op = op; last_a = a; last_b = b; end
      k = 0; ne = 0;
      while (!resp_valid && k < 40) begin
         if (alu_enable) begin
            ne++;
            chk("exec_opcode", alu_opcode, op);
            chk("exec_a", alu_a, a);
            chk("exec_b", alu_b, b);
         end
         chk("exec_ready", {req1_ready, req0_ready}, 0);
         k++;
         @(posedge clk);
         #1;
      end
      chk("resp_latency", k, lat);
      chk("enable_cycles", ne, lat);
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, g);
      chk("resp_data", resp_data, exp);
      chk("resp_err", resp_err, ill);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, exp);
         chk("hold_id", resp_id, g);
         chk("hold_ready", {req1_ready, req0_ready}, 0);
         chk("hold_enable", alu_enable, 0);
      end
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
      chk("post_valid", resp_valid, 0);
      chk("post_enable", alu_enable, 0);
      chk("held_opcode", alu_opcode, last_op);
      chk("held_a", alu_a, last_a);
      chk("held_b", alu_b, last_b);
   endtask

   initial begin
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_enable", alu_enable, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_alu_a", alu_a, 0);
      rst = 0;
      @(posedge clk);
      #1;
      load(0, 5'd0, 32'd5, 32'd7);
      serve(0);
      chk("add_result", resp_data, 32'd12);
      load(0, 5'd10, 32'hF0F0_1234, 32'h0FF0_4321);
      load(1, 5'd8, 32'hAAAA_5555, 32'h1234_FFFF);
      serve(0);
      serve(0);
      load(0, 5'd9, $urandom, $urandom);
      load(1, 5'd2, $urandom, $urandom);
      serve(0);
      serve(0);
      load(1, 5'd4, 32'd1234, 32'd5678);
      serve(0);
      load(0, 5'd20, 32'd1, 32'd2);
      serve(0);
      load(0, 5'd3, $urandom, $urandom);
      load(1, 5'd6, $urandom, $urandom);
      serve(5);
      serve(0);
      load(0, 5'd5, 32'd100, 32'd200);
      drive();
      @(posedge clk);
      #1;
      chk("fadd_enable", alu_enable, 1);
      @(posedge clk);
      #1;
      rst = 1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_enable", alu_enable, 0);
      chk("async_resp_valid", resp_valid, 0);
      chk("async_alu_opcode", alu_opcode, 0);
      model_reset();
      drive();
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("no_resp_after_rst", {busy, resp_valid}, 0);
      end
      load(0, 5'd1, $urandom, $urandom);
      load(1, 5'd11, $urandom, $urandom);
      serve(0);
      serve(0);
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < 2; i++)
            if (!v[i] && $urandom_range(0, 1) == 1) load(i, rnd_op(), $urandom, $urandom);
         if (!v[0] && !v[1]) load(int'($urandom_range(0, 1)), rnd_op(), $urandom, $urandom);
         serve(int'($urandom_range(0, 5)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
